// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment scan decoder: debounces each digit strobe, assembles
// digits 0..3 into a frame and publishes it as a 16-bit value with status pulses.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  digit_sel,
    input  logic [6:0]  seg_in,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        frame_error,
    output logic [3:0]  err_mask,
    output logic        seq_error
);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]  CNT_CAP = 8'(STABLE_CYCLES - 2);
    localparam logic [15:0] TMR_MAX = 16'(TIMEOUT_CYCLES - 1);

    // Returns {invalid, nibble}; segments are active-low g..a.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40: r = 5'h00;
            7'h79: r = 5'h01;
            7'h24: r = 5'h02;
            7'h30: r = 5'h03;
            7'h19: r = 5'h04;
            7'h12: r = 5'h05;
            7'h02: r = 5'h06;
            7'h78: r = 5'h07;
            7'h00: r = 5'h08;
            7'h18: r = 5'h09;
            7'h08: r = 5'h0A;
            7'h03: r = 5'h0B;
            7'h46: r = 5'h0C;
            7'h21: r = 5'h0D;
            7'h06: r = 5'h0E;
            7'h0E: r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    function automatic logic sel_legal(input logic [3:0] sel);
        return (sel == 4'b1110) || (sel == 4'b1101) ||
               (sel == 4'b1011) || (sel == 4'b0111);
    endfunction

    function automatic logic [1:0] sel_index(input logic [3:0] sel);
        logic [1:0] r;
        case (sel)
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       prev_sel_q;
    logic [6:0]       prev_seg_q;
    logic [7:0]       cnt_q, cnt_d;
    logic [15:0]      timer_q, timer_d;
    logic [1:0]       exp_q, exp_d;
    logic [3:0][3:0]  nib_q, nib_d;
    logic [3:0]       inv_q, inv_d;
    logic [15:0]      value_q, value_d;
    logic [3:0]       err_mask_q, err_mask_d;
    logic             value_valid_q, value_valid_d;
    logic             frame_error_q, frame_error_d;
    logic             seq_error_q, seq_error_d;

    logic             capture;
    logic [4:0]       dec;
    logic [1:0]       dig;

    assign dec = decode_seg(seg_in);
    assign dig = sel_index(digit_sel);

    // Capture fires on the single edge where the dwell reaches STABLE_CYCLES samples.
    always_comb begin
        cnt_d   = '0;
        capture = 1'b0;
        if (sel_legal(digit_sel) && digit_sel == prev_sel_q && seg_in == prev_seg_q) begin
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
            capture = (cnt_q == CNT_CAP);
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        exp_d         = exp_q;
        nib_d         = nib_q;
        inv_d         = inv_q;
        value_d       = value_q;
        err_mask_d    = err_mask_q;
        value_valid_d = 1'b0;
        frame_error_d = 1'b0;
        seq_error_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (capture && dig == 2'd0) begin
                    nib_d[0] = dec[3:0];
                    inv_d[0] = dec[4];
                    exp_d    = 2'd1;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (capture) begin
                    timer_d = '0;
                    if (dig == exp_q) begin
                        nib_d[dig] = dec[3:0];
                        inv_d[dig] = dec[4];
                        if (dig == 2'd3) begin
                            // Outputs load here so the pulse coincides with the EMIT cycle.
                            state_d    = EMIT;
                            err_mask_d = {dec[4], inv_q[2:0]};
                            if (inv_q[2:0] == 3'b000 && !dec[4]) begin
                                value_d       = {dec[3:0], nib_q[2], nib_q[1], nib_q[0]};
                                value_valid_d = 1'b1;
                            end else begin
                                frame_error_d = 1'b1;
                            end
                        end else begin
                            exp_d = exp_q + 2'd1;
                        end
                    end else begin
                        seq_error_d = 1'b1;
                        if (dig == 2'd0) begin
                            nib_d[0] = dec[3:0];
                            inv_d[0] = dec[4];
                            exp_d    = 2'd1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (timer_q == TMR_MAX) begin
                    seq_error_d = 1'b1;
                    timer_d     = '0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            EMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            prev_sel_q    <= '0;
            prev_seg_q    <= '0;
            cnt_q         <= '0;
            timer_q       <= '0;
            exp_q         <= '0;
            nib_q         <= '0;
            inv_q         <= '0;
            value_q       <= '0;
            err_mask_q    <= '0;
            value_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            seq_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_sel_q    <= digit_sel;
            prev_seg_q    <= seg_in;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            exp_q         <= exp_d;
            nib_q         <= nib_d;
            inv_q         <= inv_d;
            value_q       <= value_d;
            err_mask_q    <= err_mask_d;
            value_valid_q <= value_valid_d;
            frame_error_q <= frame_error_d;
            seq_error_q   <= seq_error_d;
        end
    end

    assign value       = value_q;
    assign err_mask    = err_mask_q;
    assign value_valid = value_valid_q;
    assign frame_error = frame_error_q;
    assign seq_error   = seq_error_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans, a decode-table sweep and a
// randomized run checked every cycle against a behavioural frame model.
module tb_seg_scan_decoder;

    localparam int STABLE = 4;
    localparam int TMO    = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel;
    logic [6:0]  seg;
    logic [15:0] value;
    logic        vv, fe, se;
    logic [3:0]  mask;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clk), .reset(rst), .digit_sel(sel), .seg_in(seg),
        .value(value), .value_valid(vv), .frame_error(fe),
        .err_mask(mask), .seq_error(se)
    );

    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [4:0] m_decode(input logic [6:0] g);
        for (int j = 0; j < 16; j++)
            if (codes[j] == g) return {1'b0, 4'(j)};
        return 5'h10;
    endfunction

    // Behavioural model: run length of identical samples plus a queue of captured digits.
    logic [10:0] m_last = '0;
    bit          m_has_last = 0;
    int          m_run = 0;
    bit          m_in_frame = 0;
    logic [4:0]  m_q[$];
    int          m_idle = 0;
    logic [15:0] m_value = '0;
    logic [3:0]  m_mask = '0;
    bit          m_vv = 0, m_fe = 0, m_se = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_has_last = 0; m_run = 0; m_in_frame = 0; m_q.delete(); m_idle = 0;
            m_value = '0; m_mask = '0; m_vv = 0; m_fe = 0; m_se = 0;
        end else begin
            int d;
            logic [4:0] e;
            m_vv = 0; m_fe = 0; m_se = 0;
            if (m_has_last && {sel, seg} == m_last) m_run++;
            else m_run = 1;
            m_last = {sel, seg};
            m_has_last = 1;
            d = 0;
            for (int i = 0; i < 4; i++) if (!sel[i]) d = i;
            e = m_decode(seg);
            if ($countones(~sel) == 1 && m_run == STABLE) begin
                m_idle = 0;
                if (!m_in_frame) begin
                    if (d == 0) begin m_q.delete(); m_q.push_back(e); m_in_frame = 1; end
                end else if (d == m_q.size()) begin
                    m_q.push_back(e);
                    if (m_q.size() == 4) begin
                        m_mask = {m_q[3][4], m_q[2][4], m_q[1][4], m_q[0][4]};
                        if (m_mask == 4'h0) begin
                            m_value = {m_q[3][3:0], m_q[2][3:0], m_q[1][3:0], m_q[0][3:0]};
                            m_vv = 1;
                        end else m_fe = 1;
                        m_in_frame = 0;
                    end
                end else begin
                    m_se = 1;
                    if (d == 0) begin m_q.delete(); m_q.push_back(e); end
                    else m_in_frame = 0;
                end
            end else if (m_in_frame) begin
                m_idle++;
                if (m_idle == TMO) begin m_se = 1; m_in_frame = 0; end
            end
        end
    end

    int tests = 0, fails = 0;
    int cyc_n = 0;
    int vv_cnt, fe_cnt, se_cnt, vv_cyc, se_cyc;
    logic [15:0] prev_good;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        vv_cnt = 0; fe_cnt = 0; se_cnt = 0; vv_cyc = -1; se_cyc = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
        if (vv === 1'b1) begin vv_cnt++; vv_cyc = cyc_n; end
        if (fe === 1'b1) fe_cnt++;
        if (se === 1'b1) begin se_cnt++; se_cyc = cyc_n; end
        tests++;
        if ({value, mask, vv, fe, se} !== {m_value, m_mask, m_vv, m_fe, m_se}) begin
            fails++;
            $display("FAIL model cyc %0d: got value=%h mask=%b vv=%b fe=%b se=%b expected value=%h mask=%b vv=%b fe=%b se=%b",
                     cyc_n, value, mask, vv, fe, se, m_value, m_mask, m_vv, m_fe, m_se);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic [6:0] g, input int n);
        sel = s; seg = g;
        repeat (n) tick();
    endtask

    task automatic scan(input logic [6:0] p0, p1, p2, p3, input int dwell);
        drive(4'hE, p0, dwell);
        drive(4'hD, p1, dwell);
        drive(4'hB, p2, dwell);
        drive(4'h7, p3, dwell);
    endtask

    typedef struct {
        logic [6:0] seg;
        logic [3:0] nib;
        logic       bad;
    } vec_t;
    vec_t vecs[19];

    initial begin
        int start;
        int pos;
        int r;
        logic [3:0] s;
        logic [6:0] g;

        vecs = '{'{7'h40, 4'h0, 1'b0}, '{7'h79, 4'h1, 1'b0}, '{7'h24, 4'h2, 1'b0},
                 '{7'h30, 4'h3, 1'b0}, '{7'h19, 4'h4, 1'b0}, '{7'h12, 4'h5, 1'b0},
                 '{7'h02, 4'h6, 1'b0}, '{7'h78, 4'h7, 1'b0}, '{7'h00, 4'h8, 1'b0},
                 '{7'h18, 4'h9, 1'b0}, '{7'h08, 4'hA, 1'b0}, '{7'h03, 4'hB, 1'b0},
                 '{7'h46, 4'hC, 1'b0}, '{7'h21, 4'hD, 1'b0}, '{7'h06, 4'hE, 1'b0},
                 '{7'h0E, 4'hF, 1'b0}, '{7'h7F, 4'h0, 1'b1}, '{7'h7E, 4'h0, 1'b1},
                 '{7'h41, 4'h0, 1'b1}};

        rst = 1'b1; sel = 4'hF; seg = 7'h7F;
        clear_counts();
        repeat (3) tick();
        check("reset value", 32'(value), 32'h0);
        check("reset err_mask", 32'(mask), 32'h0);
        check("reset pulses", 32'({vv, fe, se}), 32'h0);
        rst = 1'b0;
        drive(4'hF, 7'h7F, 2);

        // Good frame 0..3 -> 1063
        clear_counts();
        start = cyc_n;
        scan(7'h30, 7'h02, 7'h40, 7'h79, 8);
        check("good vv count", 32'(vv_cnt), 32'd1);
        check("good vv timing", 32'(vv_cyc - start), 32'd28);
        check("good value", 32'(value), 32'h1063);
        check("good err_mask", 32'(mask), 32'h0);
        check("good fe/se", 32'(fe_cnt + se_cnt), 32'd0);
        prev_good = 16'h1063;

        // Digit 2 undecodable
        clear_counts();
        scan(7'h30, 7'h02, 7'h7F, 7'h79, 8);
        check("bad fe count", 32'(fe_cnt), 32'd1);
        check("bad vv count", 32'(vv_cnt), 32'd0);
        check("bad err_mask", 32'(mask), 32'h4);
        check("bad value held", 32'(value), 32'(prev_good));

        // Decode table sweep on digit 1
        for (int i = 0; i < 19; i++) begin
            clear_counts();
            scan(7'h40, vecs[i].seg, 7'h79, 7'h24, 8);
            check("table se", 32'(se_cnt), 32'd0);
            if (!vecs[i].bad) begin
                prev_good = {4'h2, 4'h1, vecs[i].nib, 4'h0};
                check("table vv", 32'(vv_cnt), 32'd1);
                check("table value", 32'(value), 32'(prev_good));
                check("table mask", 32'(mask), 32'h0);
            end else begin
                check("table fe", 32'(fe_cnt), 32'd1);
                check("table bad mask", 32'(mask), 32'h2);
                check("table bad value", 32'(value), 32'(prev_good));
            end
        end

        // Out of order 0,2 then remaining digits ignored in IDLE
        clear_counts();
        start = cyc_n;
        drive(4'hE, 7'h30, 8);
        drive(4'hB, 7'h40, 8);
        check("order02 se timing", 32'(se_cyc - start), 32'd12);
        drive(4'hD, 7'h02, 8);
        drive(4'hB, 7'h40, 8);
        drive(4'h7, 7'h79, 8);
        check("order02 se count", 32'(se_cnt), 32'd1);
        check("order02 no vv", 32'(vv_cnt), 32'd0);
        check("order02 value", 32'(value), 32'(prev_good));

        // 0,0 restarts the frame with the second digit 0
        clear_counts();
        drive(4'hE, 7'h30, 8);
        drive(4'hF, 7'h7F, 2);
        scan(7'h19, 7'h02, 7'h40, 7'h79, 8);
        check("order00 se count", 32'(se_cnt), 32'd1);
        check("order00 vv count", 32'(vv_cnt), 32'd1);
        check("order00 value", 32'(value), 32'h1064);

        // Segment toggling every 3 cycles never captures
        clear_counts();
        for (int k = 0; k < 10; k++) drive(4'hE, (k % 2 == 1) ? 7'h40 : 7'h79, 3);
        drive(4'hD, 7'h02, 8);
        drive(4'hB, 7'h40, 8);
        drive(4'h7, 7'h79, 8);
        check("toggle pulses", 32'(vv_cnt + fe_cnt + se_cnt), 32'd0);
        check("toggle value", 32'(value), 32'h1064);

        // Reset with digit 0 held, then timeout after capture
        rst = 1'b1; sel = 4'hE; seg = 7'h40;
        repeat (3) tick();
        rst = 1'b0;
        clear_counts();
        start = cyc_n;
        drive(4'hE, 7'h40, 8);
        drive(4'hF, 7'h7F, 1100);
        check("timeout se count", 32'(se_cnt), 32'd1);
        check("timeout se timing", 32'(se_cyc - start), 32'd1028);
        check("timeout no vv", 32'(vv_cnt + fe_cnt), 32'd0);
        clear_counts();
        scan(7'h30, 7'h02, 7'h40, 7'h79, 8);
        check("post-timeout vv", 32'(vv_cnt), 32'd1);
        check("post-timeout value", 32'(value), 32'h1063);

        // Reset mid-frame discards the partial frame
        clear_counts();
        scan(7'h30, 7'h02, 7'h40, 7'h7F, 0);
        drive(4'hE, 7'h12, 8);
        drive(4'hD, 7'h79, 8);
        drive(4'hB, 7'h24, 8);
        rst = 1'b1;
        repeat (2) tick();
        check("midreset value", 32'(value), 32'h0);
        check("midreset outputs", 32'({mask, vv, fe, se}), 32'h0);
        rst = 1'b0;
        drive(4'h7, 7'h30, 8);
        check("midreset no frame", 32'(vv_cnt + fe_cnt + se_cnt), 32'd0);
        scan(7'h30, 7'h02, 7'h40, 7'h79, 8);
        check("midreset vv count", 32'(vv_cnt), 32'd1);
        check("midreset final value", 32'(value), 32'h1063);

        // Randomized traffic against the model
        pos = 0;
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                pos = 0;
            end else begin
                if (r < 75) begin
                    s = ~(4'b0001 << pos);
                    pos = (pos + 1) % 4;
                end else if (r < 92) begin
                    s = ~(4'b0001 << $urandom_range(0, 3));
                end else begin
                    s = 4'($urandom);
                end
                if ($urandom_range(0, 9) < 9) g = codes[$urandom_range(0, 15)];
                else g = 7'($urandom);
                drive(s, g, int'($urandom_range(1, 7)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
